gppcu_stall_generator: RTL and testbench

GPPCU_STALL_GENERATOR -- requirements
Module: gppcu_stall_generator

---
 rtl/gppcu_stall_generator.sv | 53 +++++
 tb/tb_gppcu_stall_generator.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/gppcu_stall_generator.sv
// Register scoreboard for the decode stage: tracks pending writes per register
// and stalls decode on RAW/WAW hazards until the writer reaches writeback.
module gppcu_stall_generator #(
   parameter int NUMREG = 32
) (
   input  logic       iACLK,
   input  logic       iRST,
   input  logic [4:0] iREGD,
   input  logic [4:0] iREGA,
   input  logic [4:0] iREGB,
   input  logic       iVALID_REGD,
   input  logic       iVALID_REGA,
   input  logic       iVALID_REGB,
   input  logic       iHOLD,
   output logic       oENABLED,
   input  logic [4:0] iWRREG,
   input  logic       iWRREG_VALID
);

   logic [NUMREG-1:0] r_pending;
   logic [NUMREG-1:0] w_pending_next;
   logic              w_hazard_a;
   logic              w_hazard_b;
   logic              w_hazard_d;
   logic              w_issue;

   // Writeback clears are deliberately not bypassed into the hazard check.
   always_comb begin
      w_hazard_a = iVALID_REGA & r_pending[iREGA];
      w_hazard_b = iVALID_REGB & r_pending[iREGB];
      w_hazard_d = iVALID_REGD & r_pending[iREGD];
   end

   assign oENABLED = ~(w_hazard_a | w_hazard_b | w_hazard_d);
   assign w_issue  = oENABLED & iVALID_REGD & ~iHOLD;

   // Clear is applied first so a same-register issue on the same edge wins.
   always_comb begin
      w_pending_next = r_pending;
      if (iWRREG_VALID)
         w_pending_next[iWRREG] = 1'b0;
      if (w_issue)
         w_pending_next[iREGD] = 1'b1;
   end

   always_ff @(posedge iACLK) begin
      if (iRST)
         r_pending <= '0;
      else
         r_pending <= w_pending_next;
   end

endmodule

// File: tb/tb_gppcu_stall_generator.sv
// Self-checking bench: directed hazard scenarios followed by randomized traffic
// compared against a scoreboard model of the pending-write set.
module tb_gppcu_stall_generator;

   logic       iACLK = 1'b0;
   logic       iRST;
   logic [4:0] iREGD, iREGA, iREGB, iWRREG;
   logic       iVALID_REGD, iVALID_REGA, iVALID_REGB, iHOLD, iWRREG_VALID;
   logic       oENABLED;

   int unsigned total = 0;
   int unsigned bad   = 0;

   // Model: set of registers with an outstanding writer.
   bit m_pend [32];

   gppcu_stall_generator #(.NUMREG(32)) dut (
      .iACLK       (iACLK),
      .iRST        (iRST),
      .iREGD       (iREGD),
      .iREGA       (iREGA),
      .iREGB       (iREGB),
      .iVALID_REGD (iVALID_REGD),
      .iVALID_REGA (iVALID_REGA),
      .iVALID_REGB (iVALID_REGB),
      .iHOLD       (iHOLD),
      .oENABLED    (oENABLED),
      .iWRREG      (iWRREG),
      .iWRREG_VALID(iWRREG_VALID)
   );

   always #5 iACLK = ~iACLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic bit model_en();
      bit stall;
      stall = (iVALID_REGA && m_pend[iREGA]) ||
              (iVALID_REGB && m_pend[iREGB]) ||
              (iVALID_REGD && m_pend[iREGD]);
      return !stall;
   endfunction

   function automatic logic [31:0] model_vec();
      logic [31:0] v;
      for (int i = 0; i < 32; i++) v[i] = m_pend[i];
      return v;
   endfunction

   task automatic set_in(input logic [4:0] d, a, b, input logic vd, va, vb, hold,
                         input logic [4:0] wr, input logic wrv, input logic rst);
      iREGD = d; iREGA = a; iREGB = b;
      iVALID_REGD = vd; iVALID_REGA = va; iVALID_REGB = vb;
      iHOLD = hold; iWRREG = wr; iWRREG_VALID = wrv; iRST = rst;
   endtask

   // Inputs change on the falling edge; enable is sampled before the rising
   // edge and the pending vector is sampled on the following falling edge.
   task automatic cycle(input string tag);
      bit en;
      #1;
      en = model_en();
      chk({tag, "_en"}, {31'd0, oENABLED}, {31'd0, en});
      @(posedge iACLK);
      if (iRST) begin
         for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      end else begin
         if (iWRREG_VALID) m_pend[iWRREG] = 1'b0;
         if (en && iVALID_REGD && !iHOLD) m_pend[iREGD] = 1'b1;
      end
      @(negedge iACLK);
      chk({tag, "_pend"}, dut.r_pending, model_vec());
   endtask

   task automatic expect_en(input string tag, input logic exp);
      #1;
      chk(tag, {31'd0, oENABLED}, {31'd0, exp});
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      @(negedge iACLK);
      cycle("rst");
      chk("rst_vec", dut.r_pending, 32'h0);

      // Scenario 1: read after reset
      set_in(0, 3, 0, 0, 1, 0, 0, 0, 0, 0);
      expect_en("s1_read3", 1'b1);
      cycle("s1");

      // Scenario 2: RAW on r5, released one edge after writeback
      set_in(5, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      cycle("s2_issue");
      set_in(0, 5, 0, 0, 1, 0, 0, 0, 0, 0);
      expect_en("s2_raw", 1'b0);
      cycle("s2_stall");
      set_in(0, 5, 0, 0, 1, 0, 0, 5, 1, 0);
      expect_en("s2_nobypass", 1'b0);
      cycle("s2_retire");
      set_in(0, 5, 0, 0, 1, 0, 0, 0, 0, 0);
      expect_en("s2_release", 1'b1);
      cycle("s2_after");

      // Scenario 3: issue and retire of r7 on the same edge -> set wins
      set_in(7, 0, 0, 1, 0, 0, 0, 7, 1, 0);
      expect_en("s3_issue_ok", 1'b1);
      cycle("s3_setwins");
      chk("s3_p7", {31'd0, dut.r_pending[7]}, 32'd1);
      set_in(0, 7, 0, 0, 1, 0, 0, 0, 0, 0);
      expect_en("s3_reader7", 1'b0);
      cycle("s3_read");
      // WAW: second writer to pending r7 stalls; different-register retire applies
      set_in(7, 0, 0, 1, 0, 0, 0, 5, 1, 0);
      expect_en("s3_waw", 1'b0);
      cycle("s3_waw");
      set_in(8, 0, 0, 1, 0, 0, 0, 7, 1, 0);
      cycle("s3_both");
      chk("s3_p7clr", {30'd0, dut.r_pending[8], dut.r_pending[7]}, 32'd2);

      // Scenario 4: held writer of r9 never self-blocks and never sets
      for (int k = 0; k < 3; k++) begin
         set_in(9, 0, 0, 1, 0, 0, 1, 0, 0, 0);
         expect_en("s4_hold_en", 1'b1);
         cycle("s4_hold");
         chk("s4_p9_clear", {31'd0, dut.r_pending[9]}, 32'd0);
      end
      set_in(9, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      cycle("s4_go");
      chk("s4_p9_set", {31'd0, dut.r_pending[9]}, 32'd1);

      // Scenario 5: invalid source B must not stall
      set_in(2, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      cycle("s5_issue");
      set_in(0, 4, 2, 0, 1, 0, 0, 0, 0, 0);
      expect_en("s5_vb0", 1'b1);
      cycle("s5_vb0");
      set_in(0, 4, 2, 0, 1, 1, 0, 0, 0, 0);
      expect_en("s5_vb1", 1'b0);
      cycle("s5_vb1");

      // Scenario 6: reset overrides simultaneous issue
      set_in(1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      cycle("s6_i1");
      set_in(31, 0, 0, 1, 0, 0, 0, 0, 0, 0);
      cycle("s6_i31");
      set_in(3, 0, 0, 1, 0, 0, 0, 2, 1, 1);
      cycle("s6_rst");
      chk("s6_vec", dut.r_pending, 32'h0);
      set_in(0, 1, 31, 0, 1, 1, 0, 0, 0, 0);
      expect_en("s6_read", 1'b1);
      cycle("s6_read");

      // Randomized traffic, biased toward a small register window for collisions
      for (int n = 0; n < 3000; n++) begin
         logic [4:0] d, a, b, wr;
         bit wide;
         wide = ($urandom_range(0, 9) == 0);
         d  = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         a  = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         b  = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         wr = wide ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
         set_in(d, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                wr, ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) == 0));
         cycle("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
